// File: rtl/egr_rrq_arb.sv
// rtl/egr_rrq_arb.sv - round-robin read-request arbiter with per-source outstanding limits
// One registered output stage toward the MRI; per-requestor outstanding counters gate eligibility.
module egr_rrq_arb #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 20,
    parameter int TAG_W     = 4,
    parameter int MAX_OUTST = 8,
    localparam int SRC_W    = $clog2(N_REQ),
    localparam int CNT_W    = $clog2(MAX_OUTST + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*TAG_W-1:0]    req_tag,
    output logic                      mri_valid,
    input  logic                      mri_ready,
    output logic [ADDR_W-1:0]         mri_addr,
    output logic [TAG_W-1:0]          mri_tag,
    output logic [SRC_W-1:0]          mri_src,
    input  logic                      rsp_valid,
    input  logic [SRC_W-1:0]          rsp_src,
    output logic [N_REQ*CNT_W-1:0]    outst_cnt,
    output logic                      err_underflow
);

    logic                 mri_valid_q, mri_valid_d;
    logic [ADDR_W-1:0]    mri_addr_q,  mri_addr_d;
    logic [TAG_W-1:0]     mri_tag_q,   mri_tag_d;
    logic [SRC_W-1:0]     mri_src_q,   mri_src_d;
    logic [SRC_W-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0]     cnt_q [N_REQ];
    logic [CNT_W-1:0]     cnt_d [N_REQ];
    logic                 err_q,       err_d;

    logic [N_REQ-1:0]     elig;
    logic                 load_ok;
    logic                 gnt_any;
    logic [SRC_W-1:0]     gnt_idx;
    logic [N_REQ-1:0]     gnt_vec;
    logic                 rsp_hit;

    // Eligibility uses registered counts only, so a completion frees a slot one cycle later.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUTST));
        end
    end

    assign load_ok = !mri_valid_q || mri_ready;

    // First eligible index starting at rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_vec = '0;
        if (!rst && load_ok) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!gnt_any && elig[(int'(rr_ptr_q) + k) % N_REQ]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SRC_W'((int'(rr_ptr_q) + k) % N_REQ);
                end
            end
        end
        if (gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    assign req_ready = gnt_vec;

    always_comb begin
        mri_valid_d = mri_valid_q;
        mri_addr_d  = mri_addr_q;
        mri_tag_d   = mri_tag_q;
        mri_src_d   = mri_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (gnt_any) begin
            mri_valid_d = 1'b1;
            mri_addr_d  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            mri_tag_d   = req_tag[int'(gnt_idx)*TAG_W +: TAG_W];
            mri_src_d   = gnt_idx;
            rr_ptr_d    = SRC_W'((int'(gnt_idx) + 1) % N_REQ);
        end else if (mri_valid_q && mri_ready) begin
            mri_valid_d = 1'b0;
        end
    end

    assign rsp_hit = rsp_valid && (int'(rsp_src) < N_REQ);

    // A grant and a completion to the same source cancel; a bare completion at zero flags underflow.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (gnt_vec[i] && !(rsp_hit && rsp_src == SRC_W'(i))) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!gnt_vec[i] && rsp_hit && rsp_src == SRC_W'(i)) begin
                if (cnt_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mri_valid_q <= 1'b0;
            mri_addr_q  <= '0;
            mri_tag_q   <= '0;
            mri_src_q   <= '0;
            rr_ptr_q    <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            mri_valid_q <= mri_valid_d;
            mri_addr_q  <= mri_addr_d;
            mri_tag_q   <= mri_tag_d;
            mri_src_q   <= mri_src_d;
            rr_ptr_q    <= rr_ptr_d;
            err_q       <= err_d;
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            outst_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign mri_valid     = mri_valid_q;
    assign mri_addr      = mri_addr_q;
    assign mri_tag       = mri_tag_q;
    assign mri_src       = mri_src_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_egr_rrq_arb.sv
// tb/tb_egr_rrq_arb.sv - directed scoreboard bench for egr_rrq_arb
module tb_egr_rrq_arb;

    localparam int N_REQ     = 4;
    localparam int ADDR_W    = 20;
    localparam int TAG_W     = 4;
    localparam int MAX_OUTST = 8;
    localparam int SRC_W     = $clog2(N_REQ);
    localparam int CNT_W     = $clog2(MAX_OUTST + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
        logic [SRC_W-1:0]  src;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic                    mri_valid;
    logic                    mri_ready;
    logic [ADDR_W-1:0]       mri_addr;
    logic [TAG_W-1:0]        mri_tag;
    logic [SRC_W-1:0]        mri_src;
    logic                    rsp_valid;
    logic [SRC_W-1:0]        rsp_src;
    logic [N_REQ*CNT_W-1:0]  outst_cnt;
    logic                    err_underflow;

    int   n_asserts = 0;
    int   n_fail    = 0;
    exp_t exp_q[$];
    int   m_cnt [N_REQ];
    int   m_rr;
    bit   m_vld;
    bit   m_err;

    egr_rrq_arb #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_tag(req_tag),
        .mri_valid(mri_valid), .mri_ready(mri_ready),
        .mri_addr(mri_addr), .mri_tag(mri_tag), .mri_src(mri_src),
        .rsp_valid(rsp_valid), .rsp_src(rsp_src),
        .outst_cnt(outst_cnt), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] dut_cnt(input int i);
        return outst_cnt[i*CNT_W +: CNT_W];
    endfunction

    // One cycle: fresh lane payloads, check DUT against the model, clock, advance the model.
    task automatic tick();
        int g;
        logic [N_REQ-1:0] exp_ready;
        logic [N_REQ*CNT_W-1:0] exp_cnt;
        exp_t e;
        for (int i = 0; i < N_REQ; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
            req_tag[i*TAG_W +: TAG_W]    = TAG_W'($urandom);
        end
        #1;
        g = -1;
        if (!rst && (!m_vld || mri_ready)) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (g < 0 && req_valid[(m_rr + k) % N_REQ] && m_cnt[(m_rr + k) % N_REQ] < MAX_OUTST)
                    g = (m_rr + k) % N_REQ;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        for (int i = 0; i < N_REQ; i++) exp_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("mri_valid", 32'(mri_valid), 32'(m_vld));
        chk("outst_cnt", 32'(outst_cnt), 32'(exp_cnt));
        chk("err_underflow", 32'(err_underflow), 32'(m_err));
        if (m_vld) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 32'(1), 32'(0));
            end else begin
                chk("mri_addr", 32'(mri_addr), 32'(exp_q[0].addr));
                chk("mri_tag",  32'(mri_tag),  32'(exp_q[0].tag));
                chk("mri_src",  32'(mri_src),  32'(exp_q[0].src));
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            m_vld = 0; m_rr = 0; m_err = 0;
            for (int i = 0; i < N_REQ; i++) m_cnt[i] = 0;
        end else begin
            if (m_vld && mri_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (g >= 0) begin
                e.addr = req_addr[g*ADDR_W +: ADDR_W];
                e.tag  = req_tag[g*TAG_W +: TAG_W];
                e.src  = SRC_W'(g);
                exp_q.push_back(e);
                m_vld = 1;
                m_rr  = (g + 1) % N_REQ;
            end else if (m_vld && mri_ready) begin
                m_vld = 0;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (g == i && !(rsp_valid && int'(rsp_src) == i)) m_cnt[i]++;
                else if (g != i && rsp_valid && int'(rsp_src) == i) begin
                    if (m_cnt[i] == 0) m_err = 1;
                    else m_cnt[i]--;
                end
            end
        end
    endtask

    task automatic drain_all();
        req_valid = '0;
        mri_ready = 1'b1;
        rsp_valid = 1'b0;
        tick();
        for (int i = 0; i < N_REQ; i++) begin
            while (m_cnt[i] > 0) begin
                rsp_valid = 1'b1;
                rsp_src   = SRC_W'(i);
                tick();
            end
        end
        rsp_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; req_tag = '0;
        mri_ready = 1'b0; rsp_valid = 1'b0; rsp_src = '0;
        m_vld = 0; m_rr = 0; m_err = 0;
        for (int i = 0; i < N_REQ; i++) m_cnt[i] = 0;
        @(posedge clk);
        #1;

        // Reset and idle, with requests held to confirm req_ready stays low under reset.
        req_valid = '1;
        tick();
        tick();
        req_valid = '0;
        rst = 1'b0;
        tick();
        chk("reset_mri_addr", 32'(mri_addr), 32'(0));
        chk("reset_mri_src",  32'(mri_src),  32'(0));
        tick();

        // Round-robin with all lanes requesting.
        req_valid = '1;
        mri_ready = 1'b1;
        for (int n = 0; n < 8; n++) tick();
        chk("rr_last_src", 32'(mri_src), 32'(3));
        drain_all();

        // Backpressure on a held request.
        req_valid = 4'b0001;
        mri_ready = 1'b0;
        tick();
        req_valid = '1;
        for (int n = 0; n < 5; n++) tick();
        mri_ready = 1'b1;
        tick();
        chk("bp_next_src", 32'(mri_src), 32'(1));
        drain_all();

        // Outstanding limit on requestor 2.
        req_valid = 4'b0100;
        for (int n = 0; n < 10; n++) tick();
        chk("limit_cnt2", 32'(dut_cnt(2)), 32'(MAX_OUTST));
        rsp_valid = 1'b1;
        rsp_src   = 2'd2;
        tick();
        rsp_valid = 1'b0;
        chk("limit_cnt2_after_rsp", 32'(dut_cnt(2)), 32'(MAX_OUTST - 1));
        tick();
        chk("limit_cnt2_regrant", 32'(dut_cnt(2)), 32'(MAX_OUTST));
        drain_all();

        // Simultaneous grant and completion to requestor 1.
        req_valid = 4'b0010;
        for (int n = 0; n < 3; n++) tick();
        rsp_valid = 1'b1;
        rsp_src   = 2'd1;
        tick();
        rsp_valid = 1'b0;
        req_valid = '0;
        tick();
        chk("simul_cnt1", 32'(dut_cnt(1)), 32'(3));
        drain_all();

        // Underflow is sticky until reset.
        rsp_valid = 1'b1;
        rsp_src   = 2'd0;
        tick();
        rsp_valid = 1'b0;
        chk("underflow_flag", 32'(err_underflow), 32'(1));
        chk("underflow_cnt0", 32'(dut_cnt(0)), 32'(0));
        for (int n = 0; n < 3; n++) tick();
        chk("underflow_sticky", 32'(err_underflow), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("underflow_cleared", 32'(err_underflow), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
